// File: rtl/conv_window_sequencer.sv
// Window sequencer for the convolution datapath: issues input-memory reads that fill
// and slide the KSIZE x KSIZE window, steps the MAC tap index and returns the controller handshakes.
module conv_window_sequencer #(
  parameter int KSIZE  = 3,
  parameter int OUT_W  = 6,
  parameter int OUT_H  = 6,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic              ALU_en,
  input  logic              shift_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              tap_valid,
  output logic [7:0]        tap_idx,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic              en_calculate,
  output logic              alu_done,
  output logic              cal_done,
  output logic              shift_done,
  output logic              acc_done,
  output logic [2:0]        dbg_state_o
);

  localparam int IN_W = OUT_W + KSIZE - 1;
  localparam logic [7:0] K8       = 8'(KSIZE);
  localparam logic [7:0] K8M1     = 8'(KSIZE - 1);
  localparam logic [7:0] TAPS     = 8'(KSIZE * KSIZE);
  localparam logic [7:0] LAST_COL = 8'(OUT_W - 1);
  localparam logic [7:0] LAST_ROW = 8'(OUT_H - 1);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LOAD       = 3'd1;
  localparam logic [2:0] S_WAIT_CALC  = 3'd2;
  localparam logic [2:0] S_CALC       = 3'd3;
  localparam logic [2:0] S_WAIT_SHIFT = 3'd4;
  localparam logic [2:0] S_SHIFT      = 3'd5;
  localparam logic [2:0] S_DONE       = 3'd6;

  // Handshakes: every done pulse is a registered, single-cycle strobe; the controller's
  // enables are levels sampled on each rising edge, and load_en low outside IDLE/DONE aborts.
  logic [2:0]        state_q, state_d;
  logic [7:0]        rc_q, rc_d;
  logic [7:0]        r_off_q, r_off_d, c_off_q, c_off_d;
  logic [7:0]        win_row_q, win_row_d, win_col_q, win_col_d;
  logic              narrow_q, narrow_d;
  logic [7:0]        row_q, row_d, col_q, col_d;
  logic [7:0]        tap_cnt_q, tap_cnt_d, tap_idx_q, tap_idx_d;
  logic              tap_valid_q, tap_valid_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              en_calc_q, en_calc_d, alu_done_q, alu_done_d, cal_done_q, cal_done_d;
  logic              shift_done_q, shift_done_d, acc_done_q, acc_done_d;
  logic              issue;
  logic [7:0]        burst_len;

  // A column advance reads one column (narrow burst); loads and row wraps read the full window.
  assign burst_len = narrow_q ? K8 : TAPS;

  always_comb begin
    state_d      = state_q;
    rc_d         = rc_q;
    r_off_d      = r_off_q;
    c_off_d      = c_off_q;
    win_row_d    = win_row_q;
    win_col_d    = win_col_q;
    narrow_d     = narrow_q;
    row_d        = row_q;
    col_d        = col_q;
    tap_cnt_d    = tap_cnt_q;
    tap_idx_d    = tap_idx_q;
    addr_d       = addr_q;
    tap_valid_d  = 1'b0;
    rd_en_d      = 1'b0;
    en_calc_d    = 1'b0;
    alu_done_d   = 1'b0;
    cal_done_d   = 1'b0;
    shift_done_d = 1'b0;
    acc_done_d   = 1'b0;
    issue        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (load_en) begin
          row_d     = 8'd0;
          col_d     = 8'd0;
          win_row_d = 8'd0;
          win_col_d = 8'd0;
          narrow_d  = 1'b0;
          r_off_d   = 8'd0;
          c_off_d   = 8'd0;
          rc_d      = 8'd0;
          state_d   = S_LOAD;
          issue     = 1'b1;
        end
      end
      S_LOAD, S_SHIFT: begin
        if (rc_q == burst_len) begin
          state_d = S_WAIT_CALC;
          if (state_q == S_LOAD) begin
            en_calc_d = 1'b1;
          end else begin
            shift_done_d = 1'b1;
            if (col_q == LAST_COL) begin
              row_d = row_q + 8'd1;
              col_d = 8'd0;
            end else begin
              col_d = col_q + 8'd1;
            end
          end
        end else begin
          issue = 1'b1;
        end
      end
      S_WAIT_CALC: begin
        if (ALU_en) begin
          state_d     = S_CALC;
          tap_valid_d = 1'b1;
          tap_idx_d   = 8'd0;
          tap_cnt_d   = 8'd1;
        end
      end
      S_CALC: begin
        if (tap_cnt_q == TAPS) begin
          alu_done_d = 1'b1;
          tap_cnt_d  = 8'd0;
          if (row_q == LAST_ROW && col_q == LAST_COL) begin
            acc_done_d = 1'b1;
            state_d    = S_DONE;
          end else begin
            cal_done_d = 1'b1;
            state_d    = S_WAIT_SHIFT;
          end
        end else if (ALU_en) begin
          tap_valid_d = 1'b1;
          tap_idx_d   = tap_cnt_q;
          tap_cnt_d   = tap_cnt_q + 8'd1;
        end
      end
      S_WAIT_SHIFT: begin
        if (shift_en) begin
          r_off_d = 8'd0;
          c_off_d = 8'd0;
          rc_d    = 8'd0;
          state_d = S_SHIFT;
          issue   = 1'b1;
          if (col_q == LAST_COL) begin
            win_row_d = row_q + 8'd1;
            win_col_d = 8'd0;
            narrow_d  = 1'b0;
          end else begin
            win_row_d = row_q;
            win_col_d = col_q + K8;
            narrow_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (!load_en) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Issue one read at the current offsets, then step row-major through the burst.
    if (issue) begin
      rd_en_d = 1'b1;
      addr_d  = ADDR_W'((int'(win_row_d) + int'(r_off_d)) * IN_W + int'(win_col_d) + int'(c_off_d));
      if (narrow_d || c_off_d == K8M1) begin
        c_off_d = 8'd0;
        r_off_d = r_off_d + 8'd1;
      end else begin
        c_off_d = c_off_d + 8'd1;
      end
      rc_d = rc_d + 8'd1;
    end

    if (!load_en && state_q != S_IDLE && state_q != S_DONE) begin
      state_d      = S_IDLE;
      rc_d         = 8'd0;
      r_off_d      = 8'd0;
      c_off_d      = 8'd0;
      win_row_d    = 8'd0;
      win_col_d    = 8'd0;
      narrow_d     = 1'b0;
      row_d        = 8'd0;
      col_d        = 8'd0;
      tap_cnt_d    = 8'd0;
      tap_idx_d    = 8'd0;
      addr_d       = addr_q;
      tap_valid_d  = 1'b0;
      rd_en_d      = 1'b0;
      en_calc_d    = 1'b0;
      alu_done_d   = 1'b0;
      cal_done_d   = 1'b0;
      shift_done_d = 1'b0;
      acc_done_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rc_q         <= 8'd0;
      r_off_q      <= 8'd0;
      c_off_q      <= 8'd0;
      win_row_q    <= 8'd0;
      win_col_q    <= 8'd0;
      narrow_q     <= 1'b0;
      row_q        <= 8'd0;
      col_q        <= 8'd0;
      tap_cnt_q    <= 8'd0;
      tap_idx_q    <= 8'd0;
      tap_valid_q  <= 1'b0;
      rd_en_q      <= 1'b0;
      addr_q       <= '0;
      en_calc_q    <= 1'b0;
      alu_done_q   <= 1'b0;
      cal_done_q   <= 1'b0;
      shift_done_q <= 1'b0;
      acc_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      rc_q         <= rc_d;
      r_off_q      <= r_off_d;
      c_off_q      <= c_off_d;
      win_row_q    <= win_row_d;
      win_col_q    <= win_col_d;
      narrow_q     <= narrow_d;
      row_q        <= row_d;
      col_q        <= col_d;
      tap_cnt_q    <= tap_cnt_d;
      tap_idx_q    <= tap_idx_d;
      tap_valid_q  <= tap_valid_d;
      rd_en_q      <= rd_en_d;
      addr_q       <= addr_d;
      en_calc_q    <= en_calc_d;
      alu_done_q   <= alu_done_d;
      cal_done_q   <= cal_done_d;
      shift_done_q <= shift_done_d;
      acc_done_q   <= acc_done_d;
    end
  end

  assign mem_rd_en    = rd_en_q;
  assign mem_addr     = addr_q;
  assign tap_valid    = tap_valid_q;
  assign tap_idx      = tap_idx_q;
  assign out_row      = row_q;
  assign out_col      = col_q;
  assign en_calculate = en_calc_q;
  assign alu_done     = alu_done_q;
  assign cal_done     = cal_done_q;
  assign shift_done   = shift_done_q;
  assign acc_done     = acc_done_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer on a 2x2-output, 3x3-kernel frame (input pitch 4).
module tb_conv_window_sequencer;

  localparam int K    = 3;
  localparam int OW   = 2;
  localparam int OH   = 2;
  localparam int AW   = 8;
  localparam int IN_W = OW + K - 1;
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_DONE = 3'd6;

  logic          clk = 1'b0;
  logic          rst, load_en, ALU_en, shift_en;
  logic          mem_rd_en, tap_valid, en_calculate, alu_done, cal_done, shift_done, acc_done;
  logic [AW-1:0] mem_addr;
  logic [7:0]    tap_idx, out_row, out_col;
  logic [2:0]    dbg_state_o;

  int            n_checks = 0;
  int            n_pass   = 0;
  logic [AW-1:0] exp_q[$];
  int            pos_row, pos_col;

  conv_window_sequencer #(.KSIZE(K), .OUT_W(OW), .OUT_H(OH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .ALU_en(ALU_en), .shift_en(shift_en),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .tap_valid(tap_valid), .tap_idx(tap_idx),
    .out_row(out_row), .out_col(out_col), .en_calculate(en_calculate), .alu_done(alu_done),
    .cal_done(cal_done), .shift_done(shift_done), .acc_done(acc_done), .dbg_state_o(dbg_state_o)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; load_en = 1'b0; ALU_en = 1'b0; shift_en = 1'b0;
    tick(); tick();
    n_checks++;
    if ({mem_rd_en, tap_valid, en_calculate, alu_done, cal_done, shift_done, acc_done,
         mem_addr, tap_idx, out_row, out_col, dbg_state_o} !== '0)
      $display("FAIL reset_outputs: got rd=%b addr=%0d tap=%b/%0d pos=%0d,%0d st=%0d required all zero",
               mem_rd_en, mem_addr, tap_valid, tap_idx, out_row, out_col, dbg_state_o);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({dbg_state_o, mem_rd_en, en_calculate} !== {ST_IDLE, 2'b00})
      $display("FAIL reset_release: got st=%0d rd=%b required st=0 rd=0", dbg_state_o, mem_rd_en);
    else n_pass++;
  endtask

  task automatic test_load;
    logic [AW-1:0] e;
    pos_row = 0; pos_col = 0;
    exp_q.delete();
    for (int r = 0; r < K; r++)
      for (int c = 0; c < K; c++) exp_q.push_back(AW'(r * IN_W + c));
    load_en = 1'b1;
    for (int i = 0; i < K * K; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({mem_rd_en, en_calculate, mem_addr} !== {1'b1, 1'b0, e})
        $display("FAIL load_read%0d: got rd=%b en_calc=%b addr=%0d required rd=1 en_calc=0 addr=%0d",
                 i, mem_rd_en, en_calculate, mem_addr, e);
      else n_pass++;
    end
    tick();
    n_checks++;
    if ({mem_rd_en, en_calculate, out_row, out_col} !== {2'b01, 16'd0})
      $display("FAIL load_en_calculate: got rd=%b en_calc=%b pos=%0d,%0d required rd=0 en_calc=1 pos=0,0",
               mem_rd_en, en_calculate, out_row, out_col);
    else n_pass++;
    tick();
    n_checks++;
    if ({mem_rd_en, en_calculate} !== 2'b00)
      $display("FAIL load_pulse_width: got rd=%b en_calc=%b required 0 0", mem_rd_en, en_calculate);
    else n_pass++;
  endtask

  // Taps count up on every cycle ALU_en is sampled high; the done pulses land the cycle after the last tap.
  task automatic test_calc(input bit fixed_pause);
    int taps = 0;
    bit seen_done = 1'b0;
    bit last;
    bit a;
    last = (pos_row == OH - 1) && (pos_col == OW - 1);
    for (int cyc = 0; cyc < 80 && !seen_done; cyc++) begin
      a = fixed_pause ? (cyc != 4) : ($urandom_range(0, 3) != 0);
      ALU_en = a;
      tick();
      n_checks++;
      if (taps == K * K) begin
        seen_done = 1'b1;
        if ({tap_valid, alu_done, cal_done, acc_done, mem_rd_en} !== {1'b0, 1'b1, ~last, last, 1'b0})
          $display("FAIL calc_done(%0d,%0d): got tv=%b alu=%b cal=%b acc=%b required tv=0 alu=1 cal=%b acc=%b",
                   pos_row, pos_col, tap_valid, alu_done, cal_done, acc_done, ~last, last);
        else n_pass++;
      end else if (a) begin
        if ({tap_valid, tap_idx, alu_done | cal_done | acc_done, mem_rd_en} !== {1'b1, 8'(taps), 2'b00})
          $display("FAIL calc_tap(%0d,%0d): got tv=%b idx=%0d done=%b required tv=1 idx=%0d done=0",
                   pos_row, pos_col, tap_valid, tap_idx, alu_done | cal_done | acc_done, taps);
        else n_pass++;
        taps++;
      end else begin
        if ({tap_valid, alu_done | cal_done | acc_done} !== 2'b00)
          $display("FAIL calc_pause(%0d,%0d): got tv=%b done=%b required 0 0",
                   pos_row, pos_col, tap_valid, alu_done | cal_done | acc_done);
        else n_pass++;
      end
    end
    if (!seen_done) begin
      n_checks++;
      $display("FAIL calc_timeout(%0d,%0d): got %0d taps and no done pulse required done", pos_row, pos_col, taps);
    end
    ALU_en = 1'b0;
    tick();
    n_checks++;
    if ({alu_done, cal_done, acc_done, tap_valid} !== 4'b0000)
      $display("FAIL calc_pulse_width: got alu=%b cal=%b acc=%b tv=%b required all 0",
               alu_done, cal_done, acc_done, tap_valid);
    else n_pass++;
  endtask

  task automatic test_shift;
    bit wrap;
    int n;
    logic [AW-1:0] e;
    wrap = (pos_col == OW - 1);
    repeat ($urandom_range(0, 3)) begin
      tick();
      n_checks++;
      if ({mem_rd_en, shift_done} !== 2'b00)
        $display("FAIL shift_wait: got rd=%b sd=%b required 0 0", mem_rd_en, shift_done);
      else n_pass++;
    end
    exp_q.delete();
    if (wrap) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K; c++) exp_q.push_back(AW'((pos_row + 1 + r) * IN_W + c));
    end else begin
      for (int r = 0; r < K; r++) exp_q.push_back(AW'((pos_row + r) * IN_W + pos_col + K));
    end
    n = exp_q.size();
    shift_en = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick();
      e = exp_q.pop_front();
      n_checks++;
      if ({mem_rd_en, shift_done, mem_addr} !== {2'b10, e})
        $display("FAIL shift_read%0d(wrap=%0d): got rd=%b sd=%b addr=%0d required rd=1 sd=0 addr=%0d",
                 i, wrap, mem_rd_en, shift_done, mem_addr, e);
      else n_pass++;
    end
    shift_en = 1'b0;
    if (wrap) begin
      pos_row++;
      pos_col = 0;
    end else begin
      pos_col++;
    end
    tick();
    n_checks++;
    if ({mem_rd_en, shift_done, out_row, out_col} !== {2'b01, 8'(pos_row), 8'(pos_col)})
      $display("FAIL shift_done(wrap=%0d): got rd=%b sd=%b pos=%0d,%0d required rd=0 sd=1 pos=%0d,%0d",
               wrap, mem_rd_en, shift_done, out_row, out_col, pos_row, pos_col);
    else n_pass++;
  endtask

  task automatic test_done;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({mem_rd_en, tap_valid, en_calculate, alu_done, cal_done, shift_done, acc_done, dbg_state_o}
          !== {7'd0, ST_DONE})
        $display("FAIL done_hold%0d: got strobes=%b st=%0d required strobes=0 st=%0d", i,
                 {mem_rd_en, tap_valid, en_calculate, alu_done, cal_done, shift_done, acc_done},
                 dbg_state_o, ST_DONE);
      else n_pass++;
    end
    load_en = 1'b0;
    tick();
    n_checks++;
    if ({dbg_state_o, mem_rd_en} !== {ST_IDLE, 1'b0})
      $display("FAIL done_release: got st=%0d required st=0", dbg_state_o);
    else n_pass++;
  endtask

  task automatic test_frame(input bit fixed_pause);
    test_load();
    test_calc(fixed_pause);
    for (int p = 1; p < OW * OH; p++) begin
      test_shift();
      test_calc(1'b0);
    end
    test_done();
  endtask

  task automatic test_abort_load;
    int n;
    n = $urandom_range(2, 7);
    load_en = 1'b1;
    repeat (n) tick();
    load_en = 1'b0;
    tick();
    n_checks++;
    if ({dbg_state_o, mem_rd_en, en_calculate, out_row, out_col} !== {ST_IDLE, 2'b00, 16'd0})
      $display("FAIL abort_state: got st=%0d rd=%b en_calc=%b pos=%0d,%0d required st=0 rd=0 en_calc=0 pos=0,0",
               dbg_state_o, mem_rd_en, en_calculate, out_row, out_col);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_checks++;
      if ({mem_rd_en, en_calculate, tap_valid} !== 3'b000)
        $display("FAIL abort_quiet%0d: got rd=%b en_calc=%b tv=%b required 0 0 0",
                 i, mem_rd_en, en_calculate, tap_valid);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back;
    test_frame(1'b0);
    test_frame(1'b0);
  endtask

  task automatic test_reset_mid_shift;
    test_load();
    test_calc(1'b0);
    shift_en = 1'b1;
    tick(); tick();
    #2;
    rst = 1'b1; load_en = 1'b0; shift_en = 1'b0;
    #1;
    n_checks++;
    if ({mem_rd_en, tap_valid, en_calculate, alu_done, cal_done, shift_done, acc_done,
         mem_addr, tap_idx, out_row, out_col, dbg_state_o} !== '0)
      $display("FAIL rst_async: got rd=%b addr=%0d sd=%b st=%0d required all zero",
               mem_rd_en, mem_addr, shift_done, dbg_state_o);
    else n_pass++;
    tick();
    n_checks++;
    if ({mem_rd_en, tap_valid, en_calculate, alu_done, cal_done, shift_done, acc_done,
         mem_addr, tap_idx, out_row, out_col, dbg_state_o} !== '0)
      $display("FAIL rst_mid_shift: got rd=%b addr=%0d sd=%b st=%0d required all zero",
               mem_rd_en, mem_addr, shift_done, dbg_state_o);
    else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      n_checks++;
      if ({shift_done, mem_rd_en, dbg_state_o} !== {2'b00, ST_IDLE})
        $display("FAIL rst_no_shift_done%0d: got sd=%b rd=%b st=%0d required 0 0 0",
                 i, shift_done, mem_rd_en, dbg_state_o);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_frame(1'b1);
    test_abort_load();
    test_back_to_back();
    test_reset_mid_shift();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no completion required finish within 500000 time units");
    $fatal(1);
  end

endmodule
